ras_spill_ctrl: RTL and testbench
=================================

RAS_SPILL_CTRL -- requirements
Module: ras_spill_ctrl

Interface
REQ-001 SHALL take parameters: W, default 32, word width; DEPTH, default 64, on-chip stack entries; FILL_THRESH, default 48, spill-start occupancy; EMPTY_THRESH, default 32, fill-start occupancy; MEM_DEPTH, default 256, spill-memory entries; MEM_BASE, default 32'h0, byte base address.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- occ  in  $clog2(DEPTH)+1  on-chip stack occupancy.
- push, pop  in  1  core stack operations this cycle.
- bottom_data  in  W  oldest on-chip entry.
- bottom_pop  out  1  drop oldest entry.
- bottom_push  out  1  insert entry below oldest.
- bottom_din  out  W  data for bottom_push.
- enc_valid  out  1  cipher request valid.
- enc_ready  in  1  cipher accepts request.
- enc_mode  out  1  0 = encrypt, 1 = decrypt.
- enc_din  out  2W  cipher input block.
- ct_valid  in  1  cipher result valid.
- ct_ready  out  1  result accepted.
- ct_din  in  2W  cipher result.
- mem_addr  out  32  byte address.
- mem_din  out  W  write data.
- mem_dout  in  W  read data.
- mem_rd, mem_wr  out  1  memory strobes.
- mem_rdy  in  1  memory completes access.
- rdy  out  1  core may push/pop.
- spill_cnt  out  $clog2(MEM_DEPTH)+1  entries in memory.
- mem_full  out  1  sticky: spill blocked.
- integrity_err  out  1  one-cycle pulse.

Function
REQ-003 FSM states SHALL be IDLE, S_ENC, S_CT, S_WRH, S_WRL, F_RDH, F_RDL, F_DEC, F_PT, F_PUSH; rdy = (state==IDLE).
REQ-004 In IDLE with push=pop=0: occ>=FILL_THRESH and spill_cnt<MEM_DEPTH -> S_ENC; otherwise occ<=EMPTY_THRESH and spill_cnt>0 -> F_RDH; otherwise stay. Spill wins if both hold.
REQ-005 In IDLE, occ>=FILL_THRESH with spill_cnt==MEM_DEPTH SHALL set mem_full; mem_full clears when a fill completes.
REQ-006 Entry k SHALL occupy byte addresses MEM_BASE+8k (hi word) and MEM_BASE+8k+4 (lo word), 32-bit wrap.
REQ-007 S_ENC: enc_valid=1, enc_mode=0, enc_din={addr_hi(k=spill_cnt), bottom_data}; advance on enc_valid&&enc_ready, pulsing bottom_pop that same cycle.
REQ-008 S_CT: ct_ready=1; capture ct_din on ct_valid -> S_WRH.
REQ-009 Memory handshake: strobe held, address and data stable, until the edge with mem_rdy=1; read data sampled on that edge; one access in flight.
REQ-010 S_WRH writes ct[2W-1:W]; S_WRL writes ct[W-1:0]; S_WRL completion increments spill_cnt -> IDLE.
REQ-011 F_RDH/F_RDL read entry k=spill_cnt-1, hi then lo; F_DEC issues enc_valid, enc_mode=1 with the reassembled block; F_PT captures ct_din.
REQ-012 F_PUSH (one cycle): decrypted upper W bits == addr_hi(k) -> bottom_push=1, bottom_din = lower W bits; else integrity_err pulse, no push; spill_cnt decrements either way -> IDLE.
REQ-013 Spill cycle latency SHALL be 4 cycles plus cipher and memory wait cycles; no state other than IDLE is skipped.
REQ-014 push/pop asserted while rdy=0 SHALL be ignored by this block.

Reset
REQ-015 arst_n low SHALL force IDLE, spill_cnt=0, mem_full=0, and every strobe, valid, ready, and pulse output to 0, mid-transfer included; an interrupted memory access is abandoned.

Structure
REQ-016 Package ras_pkg SHALL hold the state enum, default parameter constants, and the addr_hi function.
REQ-017 SHALL be a single module with no sub-modules; instantiation at the CRAS_top level, between stack and simon_top.

Verification
REQ-018 occ=48, spill_cnt=0, bottom_data=32'h0000_0011, cipher identity -> mem writes 32'h0 to 0x0 and 32'h11 to 0x4; bottom_pop one pulse; spill_cnt=1.
REQ-019 After REQ-018, occ=32 -> reads 0x0 and 0x4; bottom_push with bottom_din=32'h11; spill_cnt=0.
REQ-020 Corrupt the hi word to 32'h5 before the fill -> integrity_err pulse; no bottom_push; spill_cnt=0.
REQ-021 spill_cnt=MEM_DEPTH, occ=50 -> no mem_wr; mem_full=1; rdy stays 1.
REQ-022 mem_rdy held low 7 cycles during S_WRH -> mem_wr and mem_addr stable all 7 cycles; rdy=0 throughout.
REQ-023 arst_n low during F_RDL -> next edge shows IDLE, mem_rd=0, rdy=1, spill_cnt=0.

Source files
------------

// File: rtl/ras_pkg.sv
// ras_pkg: FSM states, default parameters and the spill-slot address helper for ras_spill_ctrl
package ras_pkg;
  typedef enum logic [3:0] {
    IDLE, S_ENC, S_CT, S_WRH, S_WRL, F_RDH, F_RDL, F_DEC, F_PT, F_PUSH
  } state_e;
  localparam int RAS_W = 32;
  localparam int RAS_DEPTH = 64;
  localparam int RAS_FILL_THRESH = 48;
  localparam int RAS_EMPTY_THRESH = 32;
  localparam int RAS_MEM_DEPTH = 256;
  localparam logic [31:0] RAS_MEM_BASE = 32'h0;
  function automatic logic [31:0] addr_hi(input logic [31:0] base, input logic [31:0] k);
    return base + (k << 3);
  endfunction
endpackage

// File: rtl/ras_spill_ctrl.sv
// ras_spill_ctrl: spills the oldest return-stack entries to memory through a cipher and fills them back with a tag check
//   core side   : occ, push, pop, bottom_data in; bottom_pop, bottom_push, bottom_din, rdy out
//   cipher side : enc_valid/enc_ready/enc_mode/enc_din request, ct_valid/ct_ready/ct_din result
//   memory side : mem_addr, mem_din, mem_rd, mem_wr out; mem_dout, mem_rdy in
//   status      : spill_cnt, mem_full (sticky), integrity_err (pulse)
module ras_spill_ctrl
  import ras_pkg::*;
#(
  parameter int W = RAS_W,
  parameter int DEPTH = RAS_DEPTH,
  parameter int FILL_THRESH = RAS_FILL_THRESH,
  parameter int EMPTY_THRESH = RAS_EMPTY_THRESH,
  parameter int MEM_DEPTH = RAS_MEM_DEPTH,
  parameter logic [31:0] MEM_BASE = RAS_MEM_BASE
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic [$clog2(DEPTH):0]         occ,
  input  logic                           push,
  input  logic                           pop,
  input  logic [W-1:0]                   bottom_data,
  output logic                           bottom_pop,
  output logic                           bottom_push,
  output logic [W-1:0]                   bottom_din,
  output logic                           enc_valid,
  input  logic                           enc_ready,
  output logic                           enc_mode,
  output logic [2*W-1:0]                 enc_din,
  input  logic                           ct_valid,
  output logic                           ct_ready,
  input  logic [2*W-1:0]                 ct_din,
  output logic [31:0]                    mem_addr,
  output logic [W-1:0]                   mem_din,
  input  logic [W-1:0]                   mem_dout,
  output logic                           mem_rd,
  output logic                           mem_wr,
  input  logic                           mem_rdy,
  output logic                           rdy,
  output logic [$clog2(MEM_DEPTH):0]     spill_cnt,
  output logic                           mem_full,
  output logic                           integrity_err
);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(MEM_DEPTH) + 1;
  localparam logic [OW-1:0] FT = OW'(FILL_THRESH);
  localparam logic [OW-1:0] ET = OW'(EMPTY_THRESH);
  localparam logic [CW-1:0] MD = CW'(MEM_DEPTH);
  state_e state_q;
  logic [CW-1:0] spill_cnt_q;
  logic mem_full_q;
  logic [2*W-1:0] blk_q;
  logic fill_ph, lo_ph, tag_ok;
  logic [CW-1:0] idx;
  logic [31:0] k_addr;
  logic [W-1:0] tag;
  // a spill targets the next free slot, a fill the most recently written one
  assign fill_ph = state_q inside {F_RDH, F_RDL, F_DEC, F_PT, F_PUSH};
  assign lo_ph = state_q == S_WRL || state_q == F_RDL;
  assign idx = fill_ph ? spill_cnt_q - 1'b1 : spill_cnt_q;
  assign k_addr = addr_hi(MEM_BASE, 32'(idx));
  assign tag = W'(k_addr);
  assign tag_ok = blk_q[2*W-1:W] == tag;
  assign rdy = state_q == IDLE;
  assign enc_valid = state_q == S_ENC || state_q == F_DEC;
  assign enc_mode = state_q == F_DEC;
  assign enc_din = state_q == S_ENC ? {tag, bottom_data} : blk_q;
  assign ct_ready = state_q == S_CT || state_q == F_PT;
  assign bottom_pop = state_q == S_ENC && enc_ready;
  assign bottom_push = state_q == F_PUSH && tag_ok;
  assign integrity_err = state_q == F_PUSH && !tag_ok;
  assign bottom_din = blk_q[W-1:0];
  assign mem_wr = state_q == S_WRH || state_q == S_WRL;
  assign mem_rd = state_q == F_RDH || state_q == F_RDL;
  assign mem_addr = k_addr + (lo_ph ? 32'd4 : 32'd0);
  assign mem_din = state_q == S_WRL ? blk_q[W-1:0] : blk_q[2*W-1:W];
  assign spill_cnt = spill_cnt_q;
  assign mem_full = mem_full_q;
  // blk_q holds the ciphertext on a spill and the read-back/decrypted block on a fill
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      spill_cnt_q <= '0;
      mem_full_q <= 1'b0;
      blk_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (occ >= FT && spill_cnt_q == MD) mem_full_q <= 1'b1;
          if (!push && !pop) begin
            if (occ >= FT && spill_cnt_q < MD) state_q <= S_ENC;
            else if (occ <= ET && spill_cnt_q != '0) state_q <= F_RDH;
          end
        end
        S_ENC: if (enc_ready) state_q <= S_CT;
        S_CT: if (ct_valid) begin
          blk_q <= ct_din;
          state_q <= S_WRH;
        end
        S_WRH: if (mem_rdy) state_q <= S_WRL;
        S_WRL: if (mem_rdy) begin
          spill_cnt_q <= spill_cnt_q + 1'b1;
          state_q <= IDLE;
        end
        F_RDH: if (mem_rdy) begin
          blk_q[2*W-1:W] <= mem_dout;
          state_q <= F_RDL;
        end
        F_RDL: if (mem_rdy) begin
          blk_q[W-1:0] <= mem_dout;
          state_q <= F_DEC;
        end
        F_DEC: if (enc_ready) state_q <= F_PT;
        F_PT: if (ct_valid) begin
          blk_q <= ct_din;
          state_q <= F_PUSH;
        end
        F_PUSH: begin
          spill_cnt_q <= spill_cnt_q - 1'b1;
          mem_full_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ras_spill_ctrl.sv
// tb_ras_spill_ctrl: randomized self-checking bench with memory/cipher responders and a queue model of spilled entries
module tb_ras_spill_ctrl;
  localparam int W = 32;
  localparam int MD = 8;
  logic clk = 1'b0, arst_n = 1'b0;
  logic [6:0] occ = 7'd40;
  logic push = 1'b0, pop = 1'b0;
  logic [W-1:0] bottom_data = '0;
  logic bottom_pop, bottom_push;
  logic [W-1:0] bottom_din;
  logic enc_valid, enc_ready, enc_mode;
  logic [2*W-1:0] enc_din;
  logic ct_valid, ct_ready;
  logic [2*W-1:0] ct_din;
  logic [31:0] mem_addr;
  logic [W-1:0] mem_din, mem_dout;
  logic mem_rd, mem_wr, mem_rdy;
  logic rdy;
  logic [3:0] spill_cnt;
  logic mem_full, integrity_err;
  int total = 0, bad = 0;
  logic [63:0] key = '0;
  int mem_lat_max = 0, cip_lat_max = 0, mem_lat_fix = -1;
  logic [31:0] mem [logic [31:0]];
  logic [W-1:0] ref_q[$];
  logic [W-1:0] push_q[$];
  int pops = 0, errs = 0;

  ras_spill_ctrl #(.W(W), .DEPTH(64), .FILL_THRESH(48), .EMPTY_THRESH(32), .MEM_DEPTH(MD), .MEM_BASE(32'h0)) dut (
    .clk(clk), .arst_n(arst_n), .occ(occ), .push(push), .pop(pop), .bottom_data(bottom_data),
    .bottom_pop(bottom_pop), .bottom_push(bottom_push), .bottom_din(bottom_din),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_mode(enc_mode), .enc_din(enc_din),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_din(ct_din),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdy(mem_rdy), .rdy(rdy), .spill_cnt(spill_cnt), .mem_full(mem_full), .integrity_err(integrity_err)
  );

  always #5 clk = ~clk;

  // memory: fixed or random wait, then completes with mem_rdy
  initial begin : mem_resp
    int cnt;
    bit busy;
    cnt = 0;
    busy = 0;
    mem_rdy = 0;
    mem_dout = '0;
    forever begin
      @(negedge clk);
      mem_rdy = 0;
      if (!arst_n) busy = 0;
      else if (mem_rd || mem_wr) begin
        if (!busy) begin
          busy = 1;
          cnt = mem_lat_fix >= 0 ? mem_lat_fix : int'($urandom_range(0, mem_lat_max));
        end
        if (cnt == 0) begin
          mem_rdy = 1;
          busy = 0;
          if (mem_wr) mem[mem_addr] = mem_din;
          else mem_dout = mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_BEEF;
        end else cnt--;
      end
    end
  end

  // cipher: encrypt adds key, decrypt subtracts it
  initial begin : cip_resp
    int cnt;
    bit pend;
    logic [63:0] res;
    cnt = 0;
    pend = 0;
    res = '0;
    enc_ready = 0;
    ct_valid = 0;
    ct_din = '0;
    forever begin
      @(negedge clk);
      enc_ready = 0;
      ct_valid = 0;
      if (!arst_n) begin
        pend = 0;
        cnt = 0;
      end else if (!pend && enc_valid) begin
        if (cnt == 0) begin
          enc_ready = 1;
          pend = 1;
          res = enc_mode ? enc_din - key : enc_din + key;
          cnt = int'($urandom_range(0, cip_lat_max));
        end else cnt--;
      end else if (pend && ct_ready) begin
        if (cnt == 0) begin
          ct_valid = 1;
          ct_din = res;
          pend = 0;
          cnt = int'($urandom_range(0, cip_lat_max));
        end else cnt--;
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      #2;
      if (bottom_pop) pops++;
      if (bottom_push) push_q.push_back(bottom_din);
      if (integrity_err) errs++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic run_op(input logic [6:0] o, output int cyc);
    occ = o;
    cyc = 0;
    tick();
    total++;
    if (rdy !== 1'b0) begin
      bad++;
      $display("FAIL op_start occ=%0d rdy=%b want 0", o, rdy);
      occ = 7'd40;
      return;
    end
    occ = 7'd40;
    cyc = 1;
    while (rdy !== 1'b1 && cyc < 400) begin
      tick();
      if (rdy !== 1'b1) cyc++;
    end
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL op_done rdy=%b want 1 after %0d cycles", rdy, cyc);
    end
  endtask

  task automatic do_spill(input logic [W-1:0] d, input logic [6:0] o, input int want_cyc);
    int k, cyc, p0;
    logic [31:0] a;
    logic [63:0] blk;
    k = ref_q.size();
    p0 = pops;
    bottom_data = d;
    run_op(o, cyc);
    ref_q.push_back(d);
    a = 32'(8 * k);
    blk = {a, d} + key;
    total++;
    if (pops - p0 != 1) begin
      bad++;
      $display("FAIL spill_pop count=%0d want 1", pops - p0);
    end
    total++;
    if (spill_cnt !== 4'(ref_q.size())) begin
      bad++;
      $display("FAIL spill_cnt got=%0d want=%0d", spill_cnt, ref_q.size());
    end
    total++;
    if (mem[a] !== blk[63:32] || mem[a+4] !== blk[31:0]) begin
      bad++;
      $display("FAIL spill_mem k=%0d got=%h_%h want=%h", k, mem[a], mem[a+4], blk);
    end
    if (want_cyc >= 0) begin
      total++;
      if (cyc != want_cyc) begin
        bad++;
        $display("FAIL spill_latency got=%0d want=%0d", cyc, want_cyc);
      end
    end
  endtask

  task automatic do_fill(input logic [6:0] o, input bit exp_err, input int want_cyc);
    int cyc, e0;
    logic [W-1:0] d, got;
    e0 = errs;
    push_q.delete();
    d = ref_q.pop_back();
    run_op(o, cyc);
    got = push_q.size() > 0 ? push_q[0] : 'x;
    total++;
    if (exp_err ? (push_q.size() != 0) : (push_q.size() != 1 || got !== d)) begin
      bad++;
      $display("FAIL fill_push n=%0d din=%h want n=%0d din=%h", push_q.size(), got, exp_err ? 0 : 1, d);
    end
    total++;
    if (errs - e0 != (exp_err ? 1 : 0)) begin
      bad++;
      $display("FAIL fill_integrity pulses=%0d want=%0d", errs - e0, exp_err ? 1 : 0);
    end
    total++;
    if (spill_cnt !== 4'(ref_q.size()) || mem_full !== 1'b0) begin
      bad++;
      $display("FAIL fill_status cnt=%0d full=%b want cnt=%0d full=0", spill_cnt, mem_full, ref_q.size());
    end
    if (want_cyc >= 0) begin
      total++;
      if (cyc != want_cyc) begin
        bad++;
        $display("FAIL fill_latency got=%0d want=%0d", cyc, want_cyc);
      end
    end
  endtask

  task automatic test_reset();
    occ = 7'd60;
    repeat (3) tick();
    total++;
    if (rdy !== 1'b1 || spill_cnt !== 4'd0 || mem_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_state rdy=%b cnt=%0d full=%b want 1 0 0", rdy, spill_cnt, mem_full);
    end
    total++;
    if ({enc_valid, ct_ready, mem_rd, mem_wr, bottom_pop, bottom_push, integrity_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want 0000000",
               {enc_valid, ct_ready, mem_rd, mem_wr, bottom_pop, bottom_push, integrity_err});
    end
    occ = 7'd40;
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    key = '0;
    do_spill(32'h0000_0011, 7'd48, 4);
    total++;
    if (mem[32'h0] !== 32'h0 || mem[32'h4] !== 32'h11) begin
      bad++;
      $display("FAIL basic_words got=%h,%h want 00000000,00000011", mem[32'h0], mem[32'h4]);
    end
    do_fill(7'd32, 0, 5);
  endtask

  task automatic test_integrity();
    key = '0;
    do_spill(32'h0000_0022, 7'd48, 4);
    mem[32'h0] = 32'h5;
    do_fill(7'd32, 1, 5);
  endtask

  task automatic test_hold();
    occ = 7'd60;
    push = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if (rdy !== 1'b1) begin
        bad++;
        $display("FAIL hold_push rdy=%b want 1", rdy);
      end
    end
    push = 1'b0;
    pop = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if (rdy !== 1'b1) begin
        bad++;
        $display("FAIL hold_pop rdy=%b want 1", rdy);
      end
    end
    pop = 1'b0;
    occ = 7'd40;
    do_spill(32'hCAFE_0001, 7'd60, 4);
    do_fill(7'd10, 0, 5);
  endtask

  task automatic test_random();
    key = {$urandom, $urandom};
    mem_lat_max = 3;
    cip_lat_max = 3;
    for (int i = 0; i < 40; i++) begin
      if (ref_q.size() == 0 || (ref_q.size() < MD && $urandom_range(0, 1) == 1))
        do_spill($urandom, 7'(48 + $urandom_range(0, 16)), -1);
      else
        do_fill(7'($urandom_range(0, 32)), 0, -1);
    end
    while (ref_q.size() > 0) do_fill(7'($urandom_range(0, 32)), 0, -1);
    mem_lat_max = 0;
    cip_lat_max = 0;
    key = '0;
  endtask

  task automatic test_mem_full();
    for (int i = 0; i < MD; i++) do_spill($urandom, 7'd48, 4);
    total++;
    if (mem_full !== 1'b0) begin
      bad++;
      $display("FAIL full_early mem_full=%b want 0", mem_full);
    end
    occ = 7'd50;
    repeat (4) begin
      tick();
      total++;
      if (rdy !== 1'b1 || mem_wr !== 1'b0) begin
        bad++;
        $display("FAIL full_blocked rdy=%b mem_wr=%b want 1 0", rdy, mem_wr);
      end
    end
    total++;
    if (mem_full !== 1'b1 || spill_cnt !== 4'(MD)) begin
      bad++;
      $display("FAIL full_flag mem_full=%b cnt=%0d want 1 %0d", mem_full, spill_cnt, MD);
    end
    occ = 7'd40;
    do_fill(7'd20, 0, 5);
  endtask

  task automatic stall_mon(input logic [31:0] want_a);
    int n;
    logic [31:0] a0;
    n = 0;
    while (mem_wr !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (mem_wr !== 1'b1 || mem_addr !== want_a) begin
      bad++;
      $display("FAIL stall_start mem_wr=%b addr=%h want 1 %h", mem_wr, mem_addr, want_a);
      return;
    end
    a0 = mem_addr;
    n = 0;
    while (mem_rdy !== 1'b1 && n < 20) begin
      total++;
      if (mem_wr !== 1'b1 || mem_addr !== a0 || rdy !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold wr=%b addr=%h rdy=%b want 1 %h 0", mem_wr, mem_addr, rdy, a0);
      end
      n++;
      tick();
    end
    total++;
    if (n != 7) begin
      bad++;
      $display("FAIL stall_cycles got=%0d want 7", n);
    end
  endtask

  task automatic test_stall();
    mem_lat_fix = 7;
    fork
      do_spill($urandom, 7'd48, 18);
      stall_mon(32'(8 * ref_q.size()));
    join
    mem_lat_fix = -1;
  endtask

  task automatic test_reset_midfill();
    int n;
    mem_lat_fix = 5;
    occ = 7'd20;
    n = 0;
    tick();
    occ = 7'd40;
    while (!(mem_rd === 1'b1 && mem_addr[2] === 1'b1) && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (mem_rd !== 1'b1 || mem_addr[2] !== 1'b1) begin
      bad++;
      $display("FAIL midfill_reach mem_rd=%b addr=%h want lo-word read", mem_rd, mem_addr);
    end
    arst_n = 1'b0;
    #1;
    total++;
    if (rdy !== 1'b1 || mem_rd !== 1'b0 || spill_cnt !== 4'd0 || mem_full !== 1'b0) begin
      bad++;
      $display("FAIL midfill_reset rdy=%b mem_rd=%b cnt=%0d full=%b want 1 0 0 0", rdy, mem_rd, spill_cnt, mem_full);
    end
    tick();
    total++;
    if (rdy !== 1'b1 || mem_rd !== 1'b0 || bottom_push !== 1'b0) begin
      bad++;
      $display("FAIL midfill_hold rdy=%b mem_rd=%b push=%b want 1 0 0", rdy, mem_rd, bottom_push);
    end
    ref_q.delete();
    mem_lat_fix = -1;
    arst_n = 1'b1;
    tick();
    do_spill(32'h1234_5678, 7'd55, 4);
    do_fill(7'd0, 0, 5);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_integrity();
    test_hold();
    test_random();
    test_mem_full();
    test_stall();
    test_reset_midfill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
